// File: rtl/sync_reader_pkg.sv
// Shared types and constants for the sync_reader block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_reader_pkg;

  // Width of the burst exponent carried on CTRL_log_length / SM_log_length.
  localparam int SM_LOG_LENGTH_WIDTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LATCH,
    ST_ADDR,
    ST_DATA,
    ST_OUT
  } state_e;

  // Byte step between consecutive ring words (BYTES_PER_WORD = DATA_WIDTH/8).
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sync_reader_addr_gen.sv
// Ring-buffer read address generator: captures start offset, steps one word, wraps at ring size.
// Latency: address valid the cycle after load/step.
// Backpressure: none; it only moves when the FSM pulses load or step.
// Ports: sys_aclk/sys_reset (sync active-high), load (capture sm_address),
//        step (advance one word), sm_address (byte offset in), addr (BUF_BASE + offset out).
module sync_reader_addr_gen #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BUF_BASE      = 0,
  parameter int BUF_LOG_SIZE  = 10
) (
  input  logic                     sys_aclk,
  input  logic                     sys_reset,
  input  logic                     load,
  input  logic                     step,
  input  logic [MM_ADDR_WIDTH-1:0] sm_address,
  output logic [MM_ADDR_WIDTH-1:0] addr
);
  import sync_reader_pkg::*;

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  // Offset register spans exactly the ring in bytes, so truncation is the modulo.
  localparam int OFF_W = BUF_LOG_SIZE + $clog2(BYTES_PER_WORD);
  localparam logic [MM_ADDR_WIDTH-1:0] BASE = MM_ADDR_WIDTH'(BUF_BASE);
  localparam logic [OFF_W-1:0] STEP = OFF_W'(BYTES_PER_WORD);

  logic [OFF_W-1:0] offset_q, offset_d;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^sm_address[MM_ADDR_WIDTH-1:OFF_W];

  always_comb begin
    offset_d = offset_q;
    if (load) begin
      offset_d = sm_address[OFF_W-1:0];
    end else if (step) begin
      // Natural overflow of the OFF_W-bit add wraps the last ring word back to 0.
      offset_d = offset_q + STEP;
    end
  end

  always_ff @(posedge sys_aclk) begin
    if (sys_reset) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign addr = BASE + MM_ADDR_WIDTH'(offset_q);

endmodule

// File: rtl/sync_reader.sv
// Consumer of the sync-manager handshake: requests a burst, reads 2^len ring words, streams them on AXIS.
// Latency: first word on M_AXIS 5 cycles after CTRL_start with zero-wait memory; then one word per 3 cycles.
// Backpressure: one read outstanding; arvalid/tvalid held with stable payload until arready/tready.
// Ports: SYS_aclk, SYS_reset (sync active-high); CTRL_start/log_length/busy/error;
//        SM_request/log_length/address (sync_manager); MEM_ar*/r* (read port); M_AXIS_t* (stream out).
// Optional: define SYNC_READER_TIMEOUT_EN to enable the ADDR/DATA watchdog (TIMEOUT_CYCLES).
module sync_reader #(
  parameter int MM_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BUF_BASE       = 0,
  parameter int BUF_LOG_SIZE   = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     SYS_aclk,
  input  logic                     SYS_reset,
  input  logic                     CTRL_start,
  input  logic [4:0]               CTRL_log_length,
  output logic                     CTRL_busy,
  output logic                     CTRL_error,
  output logic                     SM_request,
  output logic [4:0]               SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0] SM_address,
  output logic [MM_ADDR_WIDTH-1:0] MEM_araddr,
  output logic                     MEM_arvalid,
  input  logic                     MEM_arready,
  input  logic [DATA_WIDTH-1:0]    MEM_rdata,
  input  logic                     MEM_rvalid,
  output logic                     MEM_rready,
  output logic [DATA_WIDTH-1:0]    M_AXIS_tdata,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic                     M_AXIS_tlast
);
  import sync_reader_pkg::*;

  localparam logic [SM_LOG_LENGTH_WIDTH-1:0] MAX_LEN = SM_LOG_LENGTH_WIDTH'(BUF_LOG_SIZE);
  localparam int CNT_W = BUF_LOG_SIZE + 1;

  state_e                         state_q, state_d;
  logic                           busy_q, busy_d;
  logic                           sm_request_q, sm_request_d;
  logic [SM_LOG_LENGTH_WIDTH-1:0] len_q, len_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           arvalid_q, arvalid_d;
  logic                           rready_q, rready_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]          tdata_q, tdata_d;
  logic [CNT_W-1:0]               last_idx;
  logic                           ag_load, ag_step;
  logic [MM_ADDR_WIDTH-1:0]       ag_addr;

`ifdef SYNC_READER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  logic            error_q, error_d;
  logic [WD_W-1:0] wd_q, wd_d;
`else
  logic            unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Index of the final word of the burst: 2^len - 1.
  assign last_idx = (CNT_W'(1) << len_q) - CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    sm_request_d = sm_request_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    ag_load      = 1'b0;
    ag_step      = 1'b0;
`ifdef SYNC_READER_TIMEOUT_EN
    error_d      = error_q;
    wd_d         = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (CTRL_start) begin
          len_d        = (CTRL_log_length > MAX_LEN) ? MAX_LEN : CTRL_log_length;
          cnt_d        = '0;
          busy_d       = 1'b1;
          sm_request_d = 1'b1;
`ifdef SYNC_READER_TIMEOUT_EN
          error_d      = 1'b0;
`endif
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        sm_request_d = 1'b0;
        state_d      = ST_LATCH;
      end
      ST_LATCH: begin
        // sync_manager answers one cycle after the request pulse.
        ag_load   = 1'b1;
        arvalid_d = 1'b1;
        state_d   = ST_ADDR;
      end
      ST_ADDR: begin
        if (MEM_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (MEM_rvalid) begin
          rready_d = 1'b0;
          tdata_d  = MEM_rdata;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == last_idx);
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (M_AXIS_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            ag_step   = 1'b1;
            arvalid_d = 1'b1;
            state_d   = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SYNC_READER_TIMEOUT_EN
    // Watchdog counts only while waiting on the memory; any handshake rearms it.
    if ((state_q == ST_ADDR && !MEM_arready) || (state_q == ST_DATA && !MEM_rvalid)) begin
      if (wd_q == WD_LIMIT) begin
        error_d   = 1'b1;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      sm_request_q <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
`ifdef SYNC_READER_TIMEOUT_EN
      error_q      <= 1'b0;
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      sm_request_q <= sm_request_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
`ifdef SYNC_READER_TIMEOUT_EN
      error_q      <= error_d;
      wd_q         <= wd_d;
`endif
    end
  end

  sync_reader_addr_gen #(
    .MM_ADDR_WIDTH(MM_ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .BUF_BASE     (BUF_BASE),
    .BUF_LOG_SIZE (BUF_LOG_SIZE)
  ) u_addr_gen (
    .sys_aclk  (SYS_aclk),
    .sys_reset (SYS_reset),
    .load      (ag_load),
    .step      (ag_step),
    .sm_address(SM_address),
    .addr      (ag_addr)
  );

  // Address bus reads 0 whenever no request is presented, including right after reset.
  assign MEM_araddr    = arvalid_q ? ag_addr : '0;
  assign MEM_arvalid   = arvalid_q;
  assign MEM_rready    = rready_q;
  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tlast  = tlast_q;
  assign CTRL_busy     = busy_q;
  assign SM_request    = sm_request_q;
  assign SM_log_length = len_q;
`ifdef SYNC_READER_TIMEOUT_EN
  assign CTRL_error    = error_q;
`else
  assign CTRL_error    = 1'b0;
`endif

endmodule

// File: doc/sync_reader.md
Name: sync_reader

Overview:
- Consumer end of the sync-manager handshake.
- On a start pulse it does the following in order:
  - asserts SM_request with a burst length;
  - captures the read start address returned on SM_address;
  - fetches 2^log_length words from the ring buffer over a single-outstanding memory read port;
  - streams them out on an AXI-Stream master with tlast on the final word.
- Sits between the sync_manager/ring buffer and the DMA/stream path toward the PS.

Parameters:
- MM_ADDR_WIDTH, 32, width of SM_address and MEM_araddr (byte addresses).
- DATA_WIDTH, 32, sample word width; address step is DATA_WIDTH/8 bytes.
- BUF_BASE, 0, byte base address of the ring buffer.
- BUF_LOG_SIZE, 10, ring buffer size is 2^BUF_LOG_SIZE words.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- SYS_aclk  in  1  system clock.
- SYS_reset  in  1  synchronous active-high reset.
- CTRL_start  in  1  single-cycle pulse; begins a readout.
- CTRL_log_length  in  5  burst exponent; sampled on CTRL_start.
- CTRL_busy  out  1  high from accepted start until the last word handshakes.
- CTRL_error  out  1  sticky timeout flag; cleared by the next accepted start.
- SM_request  out  1  request pulse to sync_manager.
- SM_log_length  out  5  effective (clamped) burst exponent; held stable while busy.
- SM_address  in  MM_ADDR_WIDTH  byte offset of the first word inside the ring.
- MEM_araddr  out  MM_ADDR_WIDTH  read address.
- MEM_arvalid  out  1  read address valid.
- MEM_arready  in  1  read address accepted.
- MEM_rdata  in  DATA_WIDTH  read data.
- MEM_rvalid  in  1  read data valid.
- MEM_rready  out  1  read data accept.
- M_AXIS_tdata  out  DATA_WIDTH  stream data.
- M_AXIS_tvalid  out  1  stream valid.
- M_AXIS_tready  in  1  stream ready.
- M_AXIS_tlast  out  1  last word of burst.

Behaviour:
- Reset (synchronous, active-high, on any SYS_aclk edge with SYS_reset=1):
  - all outputs go to 0; FSM goes to IDLE; word counter cleared.
  - Mid-operation reset drops tvalid/arvalid at once with no tlast; an in-flight read response arriving later is discarded.
- States: IDLE, REQ, LATCH, ADDR, DATA, OUT.
- IDLE:
  - CTRL_start=1 registers len = min(CTRL_log_length, BUF_LOG_SIZE).
  - Clears CTRL_error and the word counter, sets busy, goes to REQ.
  - CTRL_start while busy is ignored.
- REQ: SM_request=1 for exactly one cycle, then go to LATCH.
- LATCH: sample SM_address (valid one cycle after the request); offset = SM_address mod 2^(BUF_LOG_SIZE)*DATA_WIDTH/8; go to ADDR.
- ADDR:
  - MEM_araddr = BUF_BASE + offset.
  - arvalid is held high with a stable address until arready; then go to DATA.
- DATA:
  - MEM_rready=1; on rvalid, capture rdata into the output register and go to OUT.
  - Only one read is ever outstanding.
- OUT:
  - tvalid=1; tlast=1 when counter = 2^len - 1. tdata and tlast are held stable until tready.
  - On the handshake: if last, clear busy and go to IDLE (start is accepted again the next cycle). Otherwise counter+1, offset advances by DATA_WIDTH/8 and wraps to 0 at ring size, go to ADDR.
- Boundary cases:
  - log_length=0 gives one word with tlast on it.
  - log_length>BUF_LOG_SIZE is clamped, and SM_log_length shows the clamped value.
  - An offset at the last ring word wraps to BUF_BASE on the next address.
- Throughput: at most one word per 3 cycles (ADDR/DATA/OUT) with zero-latency memory.

Optional Feature:
- SYNC_READER_TIMEOUT_EN defined:
  - A cycle counter runs in ADDR and DATA and resets on every arready/rvalid handshake.
  - Reaching TIMEOUT_CYCLES sets CTRL_error, drops arvalid/rready, clears busy and returns to IDLE; no partial tlast is emitted.
- Undefined: no watchdog logic; CTRL_error is tied to 0; the FSM waits indefinitely.

Decomposition:
- Shared package: FSM state enum, SM_LOG_LENGTH_WIDTH=5, and helper constant BYTES_PER_WORD = DATA_WIDTH/8.
- One natural sub-module: sync_reader_addr_gen, which handles offset capture, step, wrap and base add.

Test Plan:
- Reset, then start with log_length=3, SM_address=0x10 and zero-latency memory:
  - 8 reads at 0x10..0x2C;
  - 8 beats with tlast only on the 8th;
  - busy falls after the last handshake;
  - SM_request high exactly 1 cycle.
- BUF_LOG_SIZE=4, SM_address=0x38, log_length=2: addresses 0x38, 0x3C, 0x00, 0x04 (wrap).
- log_length=0: single read, one beat with tlast=1. log_length=20 with BUF_LOG_SIZE=10: SM_log_length=10, 1024 beats.
- Random arready/rvalid stalls plus tready low for 5 cycles:
  - araddr, tdata and tlast stay stable while stalled;
  - no word is lost or duplicated;
  - CTRL_start mid-burst is ignored.
- SYS_reset for 1 cycle mid-burst, then a new start with log_length=1:
  - outputs are 0 the cycle after reset;
  - a stale rvalid is discarded;
  - the new burst is correct.
- With SYNC_READER_TIMEOUT_EN and TIMEOUT_CYCLES=16, rvalid never asserted: CTRL_error=1 after 16 cycles, busy=0, FSM back in IDLE, and the next start clears the error.
